// File: rtl/imem_boot_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter_if
// Bundles the three buses that meet at the instruction-memory arbiter:
//   loader stream : ld_valid, ld_data, ld_last  -> ld_ready
//   IF fetch      : fetch_req, fetch_addr       -> fetch_gnt, fetch_rvalid,
//                                                  fetch_rdata, fetch_misalgn
//   IMEM port     : mem_addr, mem_wdata, mem_wen (to IMEM), mem_rdata (from IMEM)
// Modports:
//   slave  - the arbiter's view (serves loader and IF, drives the IMEM port)
//   master - the surroundings' view (loader, IF stage and IMEM instance)
// -----------------------------------------------------------------------------
interface imem_boot_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_misalgn;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready,
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_misalgn,
        output mem_addr, mem_wdata, mem_wen,
        input  mem_rdata
    );

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready,
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_misalgn,
        input  mem_addr, mem_wdata, mem_wen,
        output mem_rdata
    );
endinterface

// File: rtl/imem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter
// Owns the single-port IMEM. After reset it streams loader words into
// consecutive word addresses from BOOT_BASE while the CPU is stalled, then
// hands the port to the IF stage. A reload request in RUN drains one cycle and
// returns to BOOT. Overflowing MAX_WORDS without ld_last parks the block in ERR
// until reset.
// Ports:
//   clk_i          system clock (rising edge)
//   rst_i          synchronous active-high reset
//   reload_req_i   pulse in RUN: drain, then re-enter BOOT
//   ld_err_o       sticky image-overflow flag
//   word_count_o   words written since entering BOOT
//   boot_done_o    high while in RUN
//   cpu_stall_o    high in BOOT, DRAIN and ERR
//   bus            loader / fetch / IMEM signals (slave modport)
// -----------------------------------------------------------------------------
module imem_boot_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BOOT_BASE = {ADDR_W{1'b0}},
    parameter int                MAX_WORDS = 16384
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reload_req_i,
    output logic        ld_err_o,
    output logic [14:0] word_count_o,
    output logic        boot_done_o,
    output logic        cpu_stall_o,
    imem_boot_arbiter_if.slave bus
);

    localparam logic [1:0]  ST_BOOT  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_ERR   = 2'd3;
    localparam logic [14:0] MAX_WC   = 15'(MAX_WORDS);

    logic [1:0]        state_q, state_d;
    logic [14:0]       word_count_q, word_count_d;
    logic              ld_err_q, ld_err_d;
    logic              fetch_rvalid_q;
    logic              fetch_misalgn_q;

    logic              ld_ready_s;
    logic              fetch_gnt_s;
    logic              beat_s;
    logic [ADDR_W-1:0] load_addr_s;
    logic [ADDR_W-1:0] mem_addr_s;

    // Load address wraps modulo 2^ADDR_W by truncation to the port width.
    assign load_addr_s = BOOT_BASE + ADDR_W'({word_count_q, 2'b00});

    // Per-state handshakes and IMEM address select; reset forces all grants low.
    always_comb begin
        ld_ready_s  = 1'b0;
        fetch_gnt_s = 1'b0;
        mem_addr_s  = load_addr_s;
        case (state_q)
            ST_BOOT: begin
                ld_ready_s = (word_count_q < MAX_WC);
                mem_addr_s = load_addr_s;
            end
            ST_RUN: begin
                fetch_gnt_s = bus.fetch_req & ~reload_req_i;
                mem_addr_s  = bus.fetch_addr;
            end
            ST_DRAIN: mem_addr_s = bus.fetch_addr;
            ST_ERR:   mem_addr_s = load_addr_s;
            default:  mem_addr_s = load_addr_s;
        endcase
        if (rst_i) begin
            ld_ready_s  = 1'b0;
            fetch_gnt_s = 1'b0;
        end else begin
            ld_ready_s  = ld_ready_s;
            fetch_gnt_s = fetch_gnt_s;
        end
        beat_s = bus.ld_valid & ld_ready_s;
    end

    // Next-state, word counter and sticky error flag.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        ld_err_d     = ld_err_q;
        case (state_q)
            ST_BOOT: begin
                if (beat_s) begin
                    word_count_d = word_count_q + 15'd1;
                    // ld_last wins over overflow on the final free slot.
                    if (bus.ld_last) begin
                        state_d = ST_RUN;
                    end else if ((word_count_q + 15'd1) == MAX_WC) begin
                        state_d  = ST_ERR;
                        ld_err_d = 1'b1;
                    end else begin
                        state_d = ST_BOOT;
                    end
                end else begin
                    state_d = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (reload_req_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_d      = ST_BOOT;
                word_count_d = 15'd0;
            end
            ST_ERR: begin
                state_d  = ST_ERR;
                ld_err_d = 1'b1;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers; the fetch response flags share the edge on which IMEM samples the address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_BOOT;
            word_count_q    <= 15'd0;
            ld_err_q        <= 1'b0;
            fetch_rvalid_q  <= 1'b0;
            fetch_misalgn_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_count_q    <= word_count_d;
            ld_err_q        <= ld_err_d;
            fetch_rvalid_q  <= fetch_gnt_s;
            fetch_misalgn_q <= fetch_gnt_s & (|bus.fetch_addr[1:0]);
        end
    end

    assign bus.ld_ready      = ld_ready_s;
    assign bus.fetch_gnt     = fetch_gnt_s;
    assign bus.fetch_rvalid  = fetch_rvalid_q;
    assign bus.fetch_misalgn = fetch_misalgn_q;
    // IMEM ignores addr[1:0], so a misaligned fetch returns the aligned word.
    assign bus.fetch_rdata   = bus.mem_rdata;
    assign bus.mem_addr      = mem_addr_s;
    assign bus.mem_wdata     = bus.ld_data;
    assign bus.mem_wen       = beat_s;

    assign ld_err_o     = ld_err_q;
    assign word_count_o = word_count_q;
    assign boot_done_o  = (state_q == ST_RUN);
    assign cpu_stall_o  = ~boot_done_o;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_arbiter
// Directed bench: one arbiter with default capacity backed by a small IMEM
// model, and a second one with MAX_WORDS=4 for the overflow case.
// -----------------------------------------------------------------------------
module tb_imem_boot_arbiter;

    logic        clk;
    logic        rst;
    logic        reload;
    logic        reload4;
    logic        ld_err, ld_err4;
    logic [14:0] wc, wc4;
    logic        boot_done, boot_done4;
    logic        stall, stall4;
    int          tests;
    int          fails;
    logic [31:0] mem [0:15];
    logic [31:0] t1_data [0:3];
    logic [31:0] t3_data [0:3];

    imem_boot_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
    imem_boot_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus4 ();

    imem_boot_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reload_req_i (reload),
        .ld_err_o     (ld_err),
        .word_count_o (wc),
        .boot_done_o  (boot_done),
        .cpu_stall_o  (stall),
        .bus          (bus)
    );

    imem_boot_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WORDS(4)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .reload_req_i (reload4),
        .ld_err_o     (ld_err4),
        .word_count_o (wc4),
        .boot_done_o  (boot_done4),
        .cpu_stall_o  (stall4),
        .bus          (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM model: word-indexed, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end
    assign bus4.mem_rdata = 32'h0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        t1_data[0] = 32'h11; t1_data[1] = 32'h22; t1_data[2] = 32'h33; t1_data[3] = 32'h44;
        t3_data[0] = 32'hA1; t3_data[1] = 32'hA2; t3_data[2] = 32'hA3; t3_data[3] = 32'hA4;
        rst = 1'b1; reload = 1'b0; reload4 = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'hDEADBEEF; bus.ld_last = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = 16'h0;
        bus4.ld_valid = 1'b0; bus4.ld_data = 32'h0; bus4.ld_last = 1'b0;
        bus4.fetch_req = 1'b0; bus4.fetch_addr = 16'h0;

        // Reset: handshakes forced low, registers at reset values
        cyc();
        chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        chk("rst_word_count", {17'd0, wc}, 32'd0);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_cpu_stall", {31'd0, stall}, 32'd1);
        chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.fetch_rvalid}, 32'd0);
        chk("rst_misalgn", {31'd0, bus.fetch_misalgn}, 32'd0);
        rst = 1'b0; bus.ld_valid = 1'b0; bus.fetch_req = 1'b1;
        #1;
        chk("boot_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("boot_no_gnt", {31'd0, bus.fetch_gnt}, 32'd0);
        bus.fetch_req = 1'b0;

        // T1: four beats, last on the 4th
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1; bus.ld_data = t1_data[i]; bus.ld_last = (i == 3);
            #1;
            chk("t1_wen", {31'd0, bus.mem_wen}, 32'd1);
            chk("t1_addr", {16'd0, bus.mem_addr}, 32'(i * 4));
            chk("t1_wdata", bus.mem_wdata, t1_data[i]);
            cyc();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        #1;
        chk("t1_boot_done", {31'd0, boot_done}, 32'd1);
        chk("t1_cpu_stall", {31'd0, stall}, 32'd0);
        chk("t1_word_count", {17'd0, wc}, 32'd4);
        chk("t1_run_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("t1_run_wen", {31'd0, bus.mem_wen}, 32'd0);

        // T2: back-to-back fetches 0x8, 0xC, then misaligned 0x6
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'h8;
        #1;
        chk("t2_gnt0", {31'd0, bus.fetch_gnt}, 32'd1);
        chk("t2_addr0", {16'd0, bus.mem_addr}, 32'h8);
        cyc();
        bus.fetch_addr = 16'hC;
        #1;
        chk("t2_gnt1", {31'd0, bus.fetch_gnt}, 32'd1);
        chk("t2_rvalid0", {31'd0, bus.fetch_rvalid}, 32'd1);
        chk("t2_rdata0", bus.fetch_rdata, 32'h33);
        chk("t2_misalgn0", {31'd0, bus.fetch_misalgn}, 32'd0);
        cyc();
        bus.fetch_addr = 16'h6;
        #1;
        chk("t2_rvalid1", {31'd0, bus.fetch_rvalid}, 32'd1);
        chk("t2_rdata1", bus.fetch_rdata, 32'h44);
        cyc();
        bus.fetch_req = 1'b0;
        #1;
        chk("t2_mis_rdata", bus.fetch_rdata, 32'h22);
        chk("t2_mis_flag", {31'd0, bus.fetch_misalgn}, 32'd1);
        cyc();
        chk("t2_rvalid_idle", {31'd0, bus.fetch_rvalid}, 32'd0);
        chk("t2_misalgn_idle", {31'd0, bus.fetch_misalgn}, 32'd0);

        // T5: reload with a simultaneous fetch; prior grant still retires
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0;
        #1;
        chk("t5_pre_gnt", {31'd0, bus.fetch_gnt}, 32'd1);
        cyc();
        reload = 1'b1; bus.fetch_addr = 16'h4;
        #1;
        chk("t5_reload_gnt", {31'd0, bus.fetch_gnt}, 32'd0);
        chk("t5_prior_rvalid", {31'd0, bus.fetch_rvalid}, 32'd1);
        chk("t5_prior_rdata", bus.fetch_rdata, 32'h11);
        cyc();
        reload = 1'b0;
        #1;
        chk("t5_drain_gnt", {31'd0, bus.fetch_gnt}, 32'd0);
        chk("t5_drain_boot_done", {31'd0, boot_done}, 32'd0);
        chk("t5_drain_stall", {31'd0, stall}, 32'd1);
        chk("t5_drain_rvalid", {31'd0, bus.fetch_rvalid}, 32'd0);
        chk("t5_drain_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        cyc();
        bus.fetch_req = 1'b0;
        #1;
        chk("t5_boot_wc", {17'd0, wc}, 32'd0);
        chk("t5_boot_ld_ready", {31'd0, bus.ld_ready}, 32'd1);

        // T3: valid toggling, reload pulse on an idle BOOT cycle is ignored
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                bus.ld_valid = 1'b1; bus.ld_data = t3_data[k / 2]; bus.ld_last = (k == 6);
                #1;
                chk("t3_wen", {31'd0, bus.mem_wen}, 32'd1);
                chk("t3_addr", {16'd0, bus.mem_addr}, 32'((k / 2) * 4));
            end else begin
                bus.ld_valid = 1'b0; bus.ld_last = 1'b0; reload = (k == 1);
                #1;
                chk("t3_idle_wen", {31'd0, bus.mem_wen}, 32'd0);
            end
            cyc();
            reload = 1'b0;
        end
        chk("t3_boot_done", {31'd0, boot_done}, 32'd1);
        chk("t3_word_count", {17'd0, wc}, 32'd4);
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'hC;
        cyc();
        bus.fetch_req = 1'b0;
        #1;
        chk("t3_readback", bus.fetch_rdata, 32'hA4);

        // T6: reset in the middle of a load
        reload = 1'b1;
        cyc();
        reload = 1'b0;
        cyc();
        bus.ld_valid = 1'b1; bus.ld_data = 32'h55;
        cyc();
        bus.ld_data = 32'h66;
        cyc();
        rst = 1'b1; bus.ld_data = 32'h77;
        #1;
        chk("t6_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("t6_rst_wen", {31'd0, bus.mem_wen}, 32'd0);
        cyc();
        rst = 1'b0; bus.ld_valid = 1'b0;
        #1;
        chk("t6_wc", {17'd0, wc}, 32'd0);
        chk("t6_boot_done", {31'd0, boot_done}, 32'd0);
        bus.ld_valid = 1'b1; bus.ld_data = 32'h88;
        #1;
        chk("t6_addr0", {16'd0, bus.mem_addr}, 32'h0);
        chk("t6_wen0", {31'd0, bus.mem_wen}, 32'd1);
        cyc();
        bus.ld_data = 32'h99; bus.ld_last = 1'b1;
        #1;
        chk("t6_addr1", {16'd0, bus.mem_addr}, 32'h4);
        cyc();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        #1;
        chk("t6_boot_done_end", {31'd0, boot_done}, 32'd1);
        chk("t6_wc_end", {17'd0, wc}, 32'd2);

        // T4: overflow on the MAX_WORDS=4 instance
        for (int i = 0; i < 5; i++) begin
            bus4.ld_valid = 1'b1; bus4.ld_data = 32'hC0 + 32'(i);
            #1;
            if (i < 4) begin
                chk("t4_wen", {31'd0, bus4.mem_wen}, 32'd1);
                chk("t4_addr", {16'd0, bus4.mem_addr}, 32'(i * 4));
            end else begin
                chk("t4_full_ready", {31'd0, bus4.ld_ready}, 32'd0);
                chk("t4_full_wen", {31'd0, bus4.mem_wen}, 32'd0);
            end
            cyc();
        end
        bus4.ld_valid = 1'b0;
        #1;
        chk("t4_ld_err", {31'd0, ld_err4}, 32'd1);
        chk("t4_stall", {31'd0, stall4}, 32'd1);
        chk("t4_wc", {17'd0, wc4}, 32'd4);
        reload4 = 1'b1;
        cyc();
        reload4 = 1'b0;
        cyc();
        chk("t4_err_sticky", {31'd0, ld_err4}, 32'd1);
        chk("t4_err_stall", {31'd0, stall4}, 32'd1);
        chk("t4_err_ready", {31'd0, bus4.ld_ready}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t4_rst_clears_err", {31'd0, ld_err4}, 32'd0);
        chk("t4_rst_ready", {31'd0, bus4.ld_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
